// File: rtl/mem_dump_tx.sv
// Serial read-back of the program memory. Each dump is sent over an 8N1 UART
// line as: header byte, DEPTH data bytes in address order, then an 8-bit sum.
module mem_dump_tx #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W        = 4;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_MSB   = BIT_W'(8);
  localparam logic [BIT_W-1:0]  BIT_STOP  = BIT_W'(9);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, FIN} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  baud_cnt, baud_d;
  logic [BIT_W-1:0]  bit_idx, bit_d;
  logic [7:0]        shreg, shreg_d;
  logic [ADDR_W-1:0] data_idx, idx_d;
  logic [7:0]        chk, chk_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              rd_en_d, busy_d, done_d, tx_d;
  logic              baud_wrap;

  // State and datapath registers; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      data_idx <= '0;
      chk      <= '0;
      rd_addr  <= '0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shreg    <= shreg_d;
      data_idx <= idx_d;
      chk      <= chk_d;
      rd_addr  <= rd_addr_d;
      rd_en    <= rd_en_d;
      busy     <= busy_d;
      done     <= done_d;
      tx       <= tx_d;
    end
  end

  // Next-state, bit timing, fetch/capture and next line level
  always_comb begin
    state_d   = state;
    baud_d    = baud_cnt;
    bit_d     = bit_idx;
    shreg_d   = shreg;
    idx_d     = data_idx;
    chk_d     = chk;
    rd_addr_d = rd_addr;
    rd_en_d   = rd_en;
    busy_d    = busy;
    done_d    = 1'b0;
    tx_d      = 1'b1;
    baud_wrap = (baud_cnt == BAUD_LAST);

    case (state)
      IDLE, FIN: begin
        if (start) begin
          state_d   = HDR;
          baud_d    = '0;
          bit_d     = '0;
          shreg_d   = HEADER;
          idx_d     = '0;
          chk_d     = '0;
          rd_addr_d = '0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HDR, DATA, CHK: begin
        if (!baud_wrap) begin
          baud_d = baud_cnt + CNT_W'(1);
        end else begin
          baud_d = '0;
          if (bit_idx != BIT_STOP) begin
            bit_d = bit_idx + BIT_W'(1);
            // Entering the stop bit: present the next byte's address
            if (bit_idx == BIT_MSB) begin
              if (state == HDR) begin
                rd_en_d   = 1'b1;
                rd_addr_d = '0;
              end else if (state == DATA && data_idx != IDX_LAST) begin
                rd_addr_d = data_idx + ADDR_W'(1);
              end
            end
          end else begin
            // Last cycle of the stop bit: load the next byte back-to-back
            bit_d = '0;
            if (state == HDR) begin
              state_d = DATA;
              idx_d   = '0;
              shreg_d = rd_data;
              chk_d   = chk + rd_data;
            end else if (state == DATA) begin
              if (data_idx == IDX_LAST) begin
                state_d = CHK;
                shreg_d = chk;
                rd_en_d = 1'b0;
              end else begin
                idx_d   = data_idx + ADDR_W'(1);
                shreg_d = rd_data;
                chk_d   = chk + rd_data;
              end
            end else begin
              state_d = FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level for the coming cycle: start bit, data LSB first, stop bit
    if (state_d == HDR || state_d == DATA || state_d == CHK) begin
      if (bit_d == '0)
        tx_d = 1'b0;
      else if (bit_d == BIT_STOP)
        tx_d = 1'b1;
      else
        tx_d = shreg_d[3'(bit_d - BIT_W'(1))];
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: memory model with selectable read latency, a UART
// monitor feeding a byte scoreboard, and timing checks on done/rd_addr/rd_en.
`timescale 1ns/1ps
module tb_mem_dump_tx;

  localparam int unsigned CPB       = 10;
  localparam int unsigned DUMP_CYC  = 18 * 10 * CPB;

  logic       clk;
  logic       rst;
  logic       start;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       tx;
  logic       busy;
  logic       done;

  mem_dump_tx #(
    .CLK_HZ(1000), .BAUD(100), .DEPTH(16), .ADDR_W(4), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: rd_data follows rd_addr after lat cycles
  logic [7:0] mem [16];
  logic [3:0] hist [10];
  logic [3:0] lat = 4'd0;
  logic [3:0] sel_addr;
  assign sel_addr = (lat == 4'd0) ? rd_addr : hist[lat];
  assign rd_data  = mem[sel_addr];

  initial for (int i = 0; i < 10; i++) hist[i] = '0;
  always @(posedge clk) begin
    hist[1] <= rd_addr;
    for (int i = 2; i < 10; i++) hist[i] <= hist[i-1];
  end

  // Scoreboard of expected line bytes
  logic [7:0] exp_q [$];
  logic [7:0] last_byte = 8'h00;
  int addr_viol = 0;
  int rden_viol = 0;
  int done_cnt  = 0;

  // UART monitor: frame shape, mid-bit sampling and rd_addr change legality
  initial begin
    bit         rx_active = 1'b0;
    bit         shape_ok  = 1'b1;
    int         cnt       = 0;
    logic [7:0] rx_byte   = 8'h00;
    logic [7:0] e;
    logic [3:0] prev_addr = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rx_active = 1'b0;
        prev_addr = rd_addr;
      end else begin
        if (rx_active) begin
          cnt++;
        end else if (tx == 1'b0) begin
          rx_active = 1'b1;
          cnt       = 0;
          shape_ok  = 1'b1;
          rx_byte   = 8'h00;
        end
        if (rx_active) begin
          if (cnt < 10 && tx !== 1'b0) shape_ok = 1'b0;
          if (cnt >= 90 && tx !== 1'b1) shape_ok = 1'b0;
          if (cnt >= 15 && cnt <= 85 && (cnt % 10) == 5) rx_byte[cnt/10 - 1] = tx;
        end
        if (rd_addr != prev_addr &&
            !(rx_active && (cnt == 90 || (cnt == 0 && rd_addr == 4'd0))))
          addr_viol++;
        prev_addr = rd_addr;
        if (!busy && rd_en) rden_viol++;
        if (rx_active && cnt == 99) begin
          check_eq("frame_shape", int'(shape_ok), 1);
          if (exp_q.size() == 0) begin
            check_eq("sb_underflow", int'(rx_byte), -1);
          end else begin
            e = exp_q.pop_front();
            check_eq("rx_byte", int'(rx_byte), int'(e));
          end
          last_byte = rx_byte;
          rx_active = 1'b0;
        end
      end
    end
  end

  // done timing relative to busy rising, and idle conditions at done
  initial begin
    int  cyc  = 0;
    int  rise = 0;
    bit  busy_q = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (busy && !busy_q) rise = cyc;
        if (done) begin
          done_cnt++;
          check_eq("done_latency", cyc - rise, DUMP_CYC);
          check_eq("done_busy", int'(busy), 0);
          check_eq("done_tx", int'(tx), 1);
          check_eq("addr_change_viol", addr_viol, 0);
          check_eq("rden_idle_viol", rden_viol, 0);
        end
      end
      busy_q = busy;
    end
  end

  task automatic load_mem(input int kind);
    for (int k = 0; k < 16; k++) begin
      case (kind)
        0:       mem[k] = 8'h00;
        1:       mem[k] = 8'(8'h11 * k);
        default: mem[k] = 8'hFF;
      endcase
    end
  endtask

  task automatic push_dump();
    logic [7:0] sum = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(mem[k]);
      sum = sum + mem[k];
    end
    exp_q.push_back(sum);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_dump(input int kind, input logic [3:0] l, input logic [7:0] exp_chk);
    bit ok;
    int d0;
    load_mem(kind);
    lat = l;
    push_dump();
    d0 = done_cnt;
    pulse_start();
    check_eq("start_busy", int'(busy), 1);
    check_eq("start_tx", int'(tx), 0);
    wait_done(DUMP_CYC + 200, ok);
    check_eq("done_seen", int'(ok), 1);
    repeat (3) @(negedge clk);
    check_eq("chk_byte", int'(last_byte), int'(exp_chk));
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("idle_tx", int'(tx), 1);
  endtask

  typedef struct {
    int         kind;
    logic [3:0] l;
    logic [7:0] exp_chk;
  } vec_t;

  vec_t vecs [4];

  initial begin
    bit ok;
    int d0;

    vecs[0] = '{kind: 0, l: 4'd0, exp_chk: 8'h00};
    vecs[1] = '{kind: 1, l: 4'd0, exp_chk: 8'hF8};
    vecs[2] = '{kind: 2, l: 4'd9, exp_chk: 8'hF0};
    vecs[3] = '{kind: 1, l: 4'd9, exp_chk: 8'hF8};

    rst   = 1'b0;
    start = 1'b0;
    load_mem(0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", int'(tx), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_rd_en", int'(rd_en), 0);
    check_eq("rst_rd_addr", int'(rd_addr), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) run_dump(vecs[i].kind, vecs[i].l, vecs[i].exp_chk);

    // start re-pulsed during a dump is discarded
    load_mem(1);
    lat = 4'd0;
    push_dump();
    d0 = done_cnt;
    pulse_start();
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (494) @(posedge clk);
    pulse_start();
    repeat (1199) @(posedge clk);
    pulse_start();
    check_eq("repulse_busy", int'(busy), 1);
    wait_done(400, ok);
    check_eq("repulse_done_seen", int'(ok), 1);
    repeat (200) @(negedge clk);
    check_eq("repulse_one_done", done_cnt - d0, 1);
    check_eq("repulse_idle", int'(busy), 0);
    check_eq("repulse_sb_empty", exp_q.size(), 0);

    // start held across FIN: back-to-back dumps with a one-cycle gap
    push_dump();
    push_dump();
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    wait_done(DUMP_CYC + 200, ok);
    check_eq("b2b_first_done", int'(ok), 1);
    @(posedge clk); #1 start = 1'b0;
    check_eq("b2b_restart_busy", int'(busy), 1);
    check_eq("b2b_restart_tx", int'(tx), 0);
    wait_done(DUMP_CYC + 200, ok);
    check_eq("b2b_second_done", int'(ok), 1);
    repeat (3) @(negedge clk);
    check_eq("b2b_done_count", done_cnt - d0, 2);
    check_eq("b2b_sb_empty", exp_q.size(), 0);

    // Reset during data byte 7 (0x77, data bit 3 is a 0 on the line)
    push_dump();
    pulse_start();
    repeat (845) @(posedge clk);
    #3;
    check_eq("pre_rst_tx", int'(tx), 0);
    check_eq("pre_rst_rd_en", int'(rd_en), 1);
    rst = 1'b0;
    #1;
    check_eq("async_rst_tx", int'(tx), 1);
    check_eq("async_rst_busy", int'(busy), 0);
    check_eq("async_rst_rd_en", int'(rd_en), 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    exp_q.delete();
    @(posedge clk); #2 rst = 1'b1;
    check_eq("post_rst_rd_addr", int'(rd_addr), 0);
    repeat (50) @(negedge clk);
    check_eq("post_rst_no_done", done_cnt - d0, 0);
    check_eq("post_rst_tx", int'(tx), 1);
    run_dump(1, 4'd0, 8'hF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
# mem_dump_tx

Serial read-back engine for the 16 x 8 program memory: on a start request it reads every memory location in address order and transmits the contents over a UART TX line (8N1, LSB first). Each dump is framed as one header byte, the data bytes, and a trailing checksum. It is the reader counterpart to the switch-driven manual programming path: the top level gives it the memory address while `rd_en` is high, so a loaded program can be verified from a host.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, 434 at defaults), and it must be ≥ 4.
- `DEPTH`, default 16: number of memory locations dumped.
- `ADDR_W`, default 4: address width.
- `HEADER`, default 8'hA5: first byte of every dump.

Ports:
- `clk`, input, 1: system clock; all logic rises on the positive edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: dump request. Sampled on any cycle with `busy`=0; ignored while `busy`=1.
- `rd_en`, output, 1: high while the block owns the memory address. The top level uses it to select `rd_addr`.
- `rd_addr`, output, ADDR_W: memory read address.
- `rd_data`, input, 8: memory read data. It must be valid within CLKS_PER_BIT-1 cycles of an `rd_addr` change.
- `tx`, output, 1: serial line; idles high.
- `busy`, output, 1: dump in progress.
- `done`, output, 1: one-cycle pulse when a dump completes.

## Operation
- States:
  - IDLE
  - HDR: transmits `HEADER`.
  - DATA: transmits memory byte k, for k = 0..DEPTH-1.
  - CHK: transmits the checksum.
  - FIN: one cycle; pulses `done`, then returns to IDLE.
- Transitions:
  - IDLE → HDR on `start`=1.
  - HDR → DATA at the end of the header stop bit.
  - DATA(k) → DATA(k+1), and DATA(DEPTH-1) → CHK, at the end of each stop bit.
  - CHK → FIN at the end of the checksum stop bit.
  - FIN → IDLE unconditionally.
- Byte frame: 10 bits, each exactly CLKS_PER_BIT cycles long.
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - There are no idle cycles between bytes.
- Fetch:
  - `rd_addr` changes to the next byte's address on the first cycle of the current byte's stop bit.
  - `rd_data` is captured into the shift register on the last cycle of that stop bit.
  - The first data address (0) is presented at the start of the header stop bit.
- Checksum:
  - 8-bit accumulator, cleared when a dump is accepted.
  - Each captured data byte is added modulo 256. The header is excluded.
- Outputs:
  - `rd_en` is high from the HDR stop bit through the end of the last DATA byte; it is 0 otherwise.
  - `rd_addr` holds its last value while `rd_en`=0, and returns to 0 on reset or on start acceptance.
- Reset values: `tx`=1, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, state=IDLE, checksum=0, bit and baud counters 0.
- Reset mid-dump: `tx` returns to 1 immediately (asynchronously). The partial frame is abandoned and no `done` is issued.

## Timing
- `start`=1 in IDLE at cycle N:
  - `busy`=1 and `tx`=0 (header start bit) from cycle N+1.
- A dump occupies (DEPTH+2)·10·CLKS_PER_BIT cycles of `busy`, starting at N+1.
- FIN cycle:
  - `done`=1 and `busy`=0.
  - `tx`=1, and stays 1 until the next start bit.
- `start` is accepted in the FIN cycle; `start` held high yields back-to-back dumps with a 1-cycle `tx`-high gap.
- `start` arriving while `busy`=1 is discarded, not queued.
- Bit boundaries: the baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit index advances on the wrap.
- Address boundary: after DATA(DEPTH-1), `rd_addr` does not increment past DEPTH-1; it holds until the next start acceptance.

## Test plan
All scenarios use CLK_HZ=1000 and BAUD=100, so CLKS_PER_BIT=10.

1. **All-zero memory.** Pulse `start`, with a UART monitor sampling mid-bit.
   - Bytes received: A5, then 16 × 00, then 00.
   - `done` pulses exactly 1800 cycles after `busy` rises.
2. **Memory[k] = 0x11·k.**
   - Data bytes received are 00, 11, …, FF, in order.
   - Checksum byte = F8.
3. **All 0xFF memory with 9-cycle read latency** (the model updates `rd_data` 9 cycles after an `rd_addr` change).
   - 16 × FF received; checksum = F0.
   - No data corruption.
4. **`start` re-pulsed at cycles 5, 500 and 1700 of a dump.**
   - Exactly one dump occurs and exactly one `done`.
   - `start` held high across FIN causes a second dump whose header start bit follows 1 idle cycle.
5. **`rst` asserted mid-data-byte 7.**
   - `tx`=1 and `busy`=0 immediately; no `done`.
   - A following `start` produces a complete, correct dump beginning with A5 and address 0.
6. **Frame timing check.**
   - Every start bit is 0 for 10 cycles and every stop bit is 1 for 10 cycles.
   - `rd_addr` changes only on the first cycles of stop bits.
   - `rd_en` is low outside a dump.
